imem_prog_loader: RTL and testbench



---
 rtl/imem_prog_loader.sv | 154 +++++++++++++++
 tb/tb_imem_prog_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/imem_prog_loader.sv
// imem_prog_loader
//   Byte-stream loader for the core's instruction-memory debug write port.
//   It holds the core in reset while an image is streamed in. Each group of
//   four bytes is assembled little-endian into a 32-bit word, and words go
//   to consecutive word addresses starting at BASE_ADDR. The core is
//   released once the image is complete.
//   Frame: SYNC_BYTE, count lo, count hi, N x 4 data bytes, [checksum].
//
//   Optional feature macro: LOADER_CHECKSUM_EN
//     When defined, a trailing XOR checksum byte covers the count bytes and
//     the data bytes. A mismatch parks the loader in ERROR.
//     When undefined, there is no checksum byte and load_err is tied 0.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   rx_data, rx_valid    incoming host byte
//   rx_ready             byte accepted when rx_valid && rx_ready at posedge
//   core_rst             hold-reset request to the core (1 except in RUN)
//   dbg_wr_en            one-cycle imem write strobe
//   dbg_addr, dbg_instr  imem byte address / instruction word
//   load_done            image loaded, core running
//   load_err             image rejected (checksum build only)
module imem_prog_loader #(
    parameter int              XLEN      = 32,
    parameter int              CNT_W     = 16,
    parameter logic [XLEN-1:0] BASE_ADDR = '0,
    parameter logic [7:0]      SYNC_BYTE = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    output logic            core_rst,
    output logic            dbg_wr_en,
    output logic [XLEN-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_instr,
    output logic            load_done,
    output logic            load_err
);

    typedef enum logic [2:0] {
        IDLE, CNT_LO, CNT_HI, DATA, WRITE, RUN, CHECK, ERROR
    } state_t;

    state_t          state, state_n;
    logic [CNT_W-1:0] cnt, word_idx;
    logic [1:0]      byte_idx;
    logic [31:0]     asm_word;
    logic [XLEN-1:0] waddr;      // address of the word being assembled
    logic            acc, is_sync;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]      csum;
    localparam state_t DONE_ST = CHECK;
`else
    localparam state_t DONE_ST = RUN;
`endif

    // WRITE is the only cycle that cannot take a byte.
    assign rx_ready = (state != WRITE);
    assign acc      = rx_valid && rx_ready;
    assign is_sync  = (rx_data == SYNC_BYTE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   if (acc && is_sync) state_n = CNT_LO;
            CNT_LO: if (acc) state_n = CNT_HI;
            CNT_HI: if (acc) state_n = ({rx_data, cnt[7:0]} == 16'd0) ? DONE_ST : DATA;
            DATA:   if (acc && byte_idx == 2'd3) state_n = WRITE;
            // word_idx still holds the index of the word just written
            WRITE:  state_n = (word_idx == cnt - 1'b1) ? DONE_ST : DATA;
            RUN:    if (acc && is_sync) state_n = CNT_LO;
`ifdef LOADER_CHECKSUM_EN
            CHECK:  if (acc) state_n = (rx_data == csum) ? RUN : ERROR;
            ERROR:  if (acc && is_sync) state_n = CNT_LO;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            core_rst  <= 1'b1;
            dbg_wr_en <= 1'b0;
            dbg_addr  <= BASE_ADDR;
            dbg_instr <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            cnt       <= '0;
            word_idx  <= '0;
            byte_idx  <= '0;
            asm_word  <= '0;
            waddr     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_n;
            // Status outputs are registered copies of the next state, so
            // they change on the same edge as the state itself.
            core_rst  <= (state_n != RUN);
            load_done <= (state_n == RUN);
            dbg_wr_en <= (state_n == WRITE);
`ifdef LOADER_CHECKSUM_EN
            load_err  <= (state_n == ERROR);
`else
            load_err  <= 1'b0;
`endif
            case (state)
                IDLE, RUN, ERROR: begin
`ifdef LOADER_CHECKSUM_EN
                    if (acc && is_sync) csum <= '0;
`endif
                end
                CNT_LO: if (acc) begin
                    cnt[7:0] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                    csum <= csum ^ rx_data;
`endif
                end
                CNT_HI: if (acc) begin
                    cnt[15:8] <= rx_data;
                    word_idx  <= '0;
                    byte_idx  <= '0;
                    waddr     <= BASE_ADDR;
                    dbg_addr  <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    csum <= csum ^ rx_data;
`endif
                end
                DATA: if (acc) begin
                    asm_word[{byte_idx, 3'b000} +: 8] <= rx_data;
                    byte_idx <= byte_idx + 1'b1;
                    // Last byte: present the complete word with the strobe.
                    if (byte_idx == 2'd3) begin
                        dbg_instr <= {rx_data, asm_word[23:0]};
                        dbg_addr  <= waddr;
                    end
`ifdef LOADER_CHECKSUM_EN
                    csum <= csum ^ rx_data;
`endif
                end
                WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    waddr    <= waddr + XLEN'(4);   // wraps modulo 2^XLEN
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_prog_loader.sv
module tb_imem_prog_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, core_rst, dbg_wr_en, load_done, load_err;
    logic [31:0] dbg_addr, dbg_instr;

    imem_prog_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .core_rst(core_rst), .dbg_wr_en(dbg_wr_en),
        .dbg_addr(dbg_addr), .dbg_instr(dbg_instr),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, rdy_bad = 0;
    bit mon_en = 1'b0;
    logic [31:0] wa[$], wi[$];

    // Record writes and watch that rx_ready drops only with the write strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dbg_wr_en) begin
                wa.push_back(dbg_addr);
                wi.push_back(dbg_instr);
            end
            if (rx_ready !== !dbg_wr_en) rdy_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("rdy_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Sends a stream; the checksum (feature build) covers bytes from index skip.
    task automatic send_img(input logic [7:0] q[$], input int maxgap, input int skip);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < q.size(); i++) begin
            if (i >= skip) x = x ^ q[i];
            send(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        end
`ifdef LOADER_CHECKSUM_EN
        send(x, 0);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_core_rst", {31'd0, core_rst}, 32'd1);
        chk("rst_wr_en", {31'd0, dbg_wr_en}, 32'd0);
        chk("rst_addr", dbg_addr, 32'd0);
        chk("rst_instr", dbg_instr, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_rdy", {31'd0, rx_ready}, 32'd1);
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic chk_img1(input string tag);
        chk({tag, "_nwr"}, wa.size(), 32'd2);
        chk({tag, "_a0"}, wa[0], 32'h0);
        chk({tag, "_i0"}, wi[0], 32'h00000013);
        chk({tag, "_a1"}, wa[1], 32'h4);
        chk({tag, "_i1"}, wi[1], 32'h00100093);
    endtask

    logic [7:0] img1[$], q[$];

    initial begin
        img1 = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00};
        do_reset();

        // Two-word image, back to back, with release latency.
        wa.delete(); wi.delete();
        send_img(img1, 0, 1);
`ifdef LOADER_CHECKSUM_EN
        @(negedge clk);
        chk("s1_core_rst_lo", {31'd0, core_rst}, 32'd0);
`else
        @(negedge clk);
        chk("s1_wr_last", {31'd0, dbg_wr_en}, 32'd1);
        chk("s1_core_rst_hold", {31'd0, core_rst}, 32'd1);
        @(negedge clk);
        chk("s1_core_rst_lo", {31'd0, core_rst}, 32'd0);
`endif
        chk("s1_done", {31'd0, load_done}, 32'd1);
        chk_img1("s1");

        // Same image with random gaps; restarted from RUN.
        wa.delete(); wi.delete();
        send_img(img1, 7, 1);
        repeat (3) @(negedge clk);
        chk_img1("s3");
        chk("s3_done", {31'd0, load_done}, 32'd1);

        // Garbage dropped in IDLE, then an empty image.
        do_reset();
        wa.delete(); wi.delete();
        send(8'h00, 0);
        send(8'hFF, 0);
        chk("s4_idle_core_rst", {31'd0, core_rst}, 32'd1);
        q = '{8'hA5, 8'h00, 8'h00};
        send_img(q, 0, 1);
        repeat (3) @(negedge clk);
        chk("s4_nwr", wa.size(), 32'd0);
        chk("s4_core_rst", {31'd0, core_rst}, 32'd0);
        chk("s4_done", {31'd0, load_done}, 32'd1);

        // Restart from RUN.
        send(8'hA5, 0);
        chk("s5_core_rst", {31'd0, core_rst}, 32'd1);
        chk("s5_done", {31'd0, load_done}, 32'd0);
        q = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00};
        send_img(q, 0, 0);
        repeat (3) @(negedge clk);
        chk("s5_nwr", wa.size(), 32'd1);
        chk("s5_a0", wa[0], 32'h0);
        chk("s5_i0", wi[0], 32'h00000073);
        chk("s5_done2", {31'd0, load_done}, 32'd1);

        // Reset in the middle of word 0, then a full reload.
        wa.delete(); wi.delete();
        q = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB};
        foreach (q[i]) send(q[i], 0);
        do_reset();
        chk("s6_nwr0", wa.size(), 32'd0);
        send_img(img1, 0, 1);
        repeat (3) @(negedge clk);
        chk_img1("s6");
        chk("s6_done", {31'd0, load_done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Good checksum, then bad checksum.
        wa.delete(); wi.delete();
        q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23};
        foreach (q[i]) send(q[i], 0);
        @(negedge clk);
        chk("ck_nwr", wa.size(), 32'd1);
        chk("ck_i0", wi[0], 32'hDEADBEEF);
        chk("ck_run", {31'd0, load_done}, 32'd1);
        q[7] = 8'h24;
        foreach (q[i]) send(q[i], 0);
        repeat (3) @(negedge clk);
        chk("ck_err", {31'd0, load_err}, 32'd1);
        chk("ck_core_rst", {31'd0, core_rst}, 32'd1);
        chk("ck_nwr2", wa.size(), 32'd2);
`endif

        chk("rdy_only_in_write", rdy_bad, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
